// File: rtl/m6809_sys_glue_pkg.sv
// Shared types and default constants for the 6809 card glue CPLD.
package m6809_glue_pkg;

    typedef enum logic {HOLD, RUN} rst_state_t;

    // Bus-state encodings, bit order {BA, BS}.
    typedef enum logic [1:0] {
        BUS_NORMAL = 2'b00,
        BUS_IACK   = 2'b01,
        BUS_SYNC   = 2'b10,
        BUS_HALT   = 2'b11
    } bus_state_t;

    localparam logic [7:0] DEF_IO_PAGE   = 8'hFC;
    localparam logic [3:0] DEF_UART_SLOT = 4'h0;
    localparam int         DEF_RST_HOLD  = 1024;
    localparam int         DEF_DEBOUNCE  = 16;
    localparam int         DEF_AUX_DIV   = 8;

endpackage

// File: rtl/m6809_sys_glue_if.sv
// 6809 CPU-side bus pins and the decode outputs derived from them.
interface m6809_sys_glue_if;
    logic        ECLK;
    logic        QCLK;
    logic        BA;
    logic        BS;
    logic [15:0] A;
    logic        SYS_A8;
    logic        CSIO_B;
    logic        CSUART_B;
    logic        SYS_ECLK;

    modport master (output ECLK, QCLK, BA, BS, A,
                    input  SYS_A8, CSIO_B, CSUART_B, SYS_ECLK);
    modport slave  (input  ECLK, QCLK, BA, BS, A,
                    output SYS_A8, CSIO_B, CSUART_B, SYS_ECLK);
endinterface

// File: rtl/m6809_sys_glue_sync2.sv
// Two-flop synchronizer with selectable reset level; 2 clocks of latency.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/m6809_sys_glue.sv
// 6809 card glue: stretched/debounced reset, bus-state strobes, vector remap,
// E-qualified chip selects and Q/aux clock select. Strobes lag BA/BS by 3 clocks.
module m6809_sys_glue
    import m6809_glue_pkg::*;
#(
    parameter int         RST_HOLD  = DEF_RST_HOLD,
    parameter int         DEBOUNCE  = DEF_DEBOUNCE,
    parameter logic [7:0] IO_PAGE   = DEF_IO_PAGE,
    parameter logic [3:0] UART_SLOT = DEF_UART_SLOT,
    parameter int         AUX_DIV   = DEF_AUX_DIV
) (
    input  logic                   AUXCLK,
    input  logic                   RST,
    input  logic                   SW_RST_B,
    input  logic                   CPC_BUSRST_B,
    input  logic                   DIP0,
    input  logic                   DIP1,
    m6809_sys_glue_if.slave        bus,
    output logic                   RST_B,
    output logic                   IACK_B,
    output logic                   BUSACK_B,
    output logic                   SYS_Q_AUXCLK
);
    localparam int HW = $clog2(RST_HOLD);
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int VW = $clog2(AUX_DIV);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);
    localparam logic [VW-1:0] DIV_LAST  = VW'(AUX_DIV / 2 - 1);

    logic sw_s, busrst_s, ba_s, bs_s;

    sync2 #(.RST_VAL(1'b1)) u_sync_sw  (.clk(AUXCLK), .rst(RST), .d(SW_RST_B),     .q(sw_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_cpc (.clk(AUXCLK), .rst(RST), .d(CPC_BUSRST_B), .q(busrst_s));
    sync2 #(.RST_VAL(1'b0)) u_sync_ba  (.clk(AUXCLK), .rst(RST), .d(bus.BA),       .q(ba_s));
    sync2 #(.RST_VAL(1'b0)) u_sync_bs  (.clk(AUXCLK), .rst(RST), .d(bus.BS),       .q(bs_s));

    // Switch debounce: accept a new level only after DEBOUNCE consecutive differing samples.
    logic          sw_db;
    logic [DW-1:0] db_cnt;

    always_ff @(posedge AUXCLK) begin
        if (RST) begin
            sw_db  <= 1'b1;
            db_cnt <= '0;
        end else if (sw_s == sw_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            sw_db  <= sw_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    rst_state_t    state;
    logic [HW-1:0] hold_cnt;
    logic          cause;
    bus_state_t    bus_st;
    logic          iack_d, busack_d;

    assign cause    = !sw_db || !busrst_s;
    assign bus_st   = bus_state_t'({ba_s, bs_s});
    assign iack_d   = (bus_st != BUS_IACK);
    assign busack_d = (bus_st != BUS_HALT);

    // Strobes are gated with the state being entered so they never pulse in HOLD.
    always_ff @(posedge AUXCLK) begin
        if (RST) begin
            state    <= HOLD;
            hold_cnt <= '0;
            RST_B    <= 1'b0;
            IACK_B   <= 1'b1;
            BUSACK_B <= 1'b1;
        end else if (state == HOLD) begin
            if (cause) begin
                hold_cnt <= '0;
                RST_B    <= 1'b0;
                IACK_B   <= 1'b1;
                BUSACK_B <= 1'b1;
            end else if (hold_cnt == HOLD_LAST) begin
                state    <= RUN;
                hold_cnt <= '0;
                RST_B    <= 1'b1;
                IACK_B   <= iack_d;
                BUSACK_B <= busack_d;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
                RST_B    <= 1'b0;
                IACK_B   <= 1'b1;
                BUSACK_B <= 1'b1;
            end
        end else begin
            if (cause) begin
                state    <= HOLD;
                hold_cnt <= '0;
                RST_B    <= 1'b0;
                IACK_B   <= 1'b1;
                BUSACK_B <= 1'b1;
            end else begin
                RST_B    <= 1'b1;
                IACK_B   <= iack_d;
                BUSACK_B <= busack_d;
            end
        end
    end

    // Vector fetch drives its address in the same cycle, so remap and selects stay combinational.
    logic cs_io;

    assign bus.SYS_A8   = bus.A[8] ^ (bus.BS & ~bus.BA);
    assign cs_io        = (bus.A[15:8] == IO_PAGE) && bus.ECLK && RST_B;
    assign bus.CSIO_B   = !cs_io;
    assign bus.CSUART_B = !(cs_io && (bus.A[7:4] == UART_SLOT));
    assign bus.SYS_ECLK = bus.ECLK;

    logic          div_q, dip1_q;
    logic [VW-1:0] div_cnt;

    always_ff @(posedge AUXCLK) begin
        if (RST) begin
            div_cnt <= '0;
            div_q   <= 1'b0;
            dip1_q  <= 1'b0;
        end else begin
            dip1_q <= DIP1;
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                div_q   <= ~div_q;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    assign SYS_Q_AUXCLK = dip1_q ? bus.QCLK : div_q;

    logic unused;
    assign unused = ^{DIP0, bus.A[3:0]};

endmodule

// File: tb/tb_m6809_sys_glue.sv
// Bench for m6809_sys_glue: decode vector table, reset/debounce/hold sequences, random bus-state stream.
module tb_m6809_sys_glue;
    logic AUXCLK = 1'b0;
    logic RST, SW_RST_B, CPC_BUSRST_B, DIP0, DIP1;
    logic RST_B, IACK_B, BUSACK_B, SYS_Q_AUXCLK;

    always #5 AUXCLK = ~AUXCLK;

    m6809_sys_glue_if bus ();

    m6809_sys_glue #(
        .RST_HOLD(8), .DEBOUNCE(16), .IO_PAGE(8'hFC), .UART_SLOT(4'h0), .AUX_DIV(8)
    ) dut (
        .AUXCLK(AUXCLK), .RST(RST), .SW_RST_B(SW_RST_B), .CPC_BUSRST_B(CPC_BUSRST_B),
        .DIP0(DIP0), .DIP1(DIP1), .bus(bus),
        .RST_B(RST_B), .IACK_B(IACK_B), .BUSACK_B(BUSACK_B), .SYS_Q_AUXCLK(SYS_Q_AUXCLK)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge AUXCLK);
        #1;
    endtask

    typedef struct {
        logic [15:0] a;
        logic        e, ba, bs;
        logic        a8, csio, csuart;
    } vec_t;

    vec_t vecs[9];

    typedef struct { logic iack; logic busack; } st_exp_t;
    st_exp_t q[$];

    logic samp[32];

    initial begin
        vecs[0] = '{16'hFC05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFC15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{16'hFC05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{16'hFB05, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{16'h0100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{16'hFC4F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{16'hFD00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        RST = 1'b1; SW_RST_B = 1'b1; CPC_BUSRST_B = 1'b1; DIP0 = 1'b0; DIP1 = 1'b0;
        bus.ECLK = 1'b1; bus.QCLK = 1'b0; bus.BA = 1'b0; bus.BS = 1'b0; bus.A = 16'hFC00;
        tick(); tick();
        chk("reset RST_B", RST_B, 1'b0);
        chk("reset IACK_B", IACK_B, 1'b1);
        chk("reset BUSACK_B", BUSACK_B, 1'b1);
        chk("reset SYS_Q_AUXCLK", SYS_Q_AUXCLK, 1'b0);
        chk("reset CSIO_B", bus.CSIO_B, 1'b1);
        chk("reset CSUART_B", bus.CSUART_B, 1'b1);

        // Power-on hold: low for exactly 8 edges, no chip selects meanwhile.
        RST = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i < 8) begin
                chk("por hold RST_B", RST_B, 1'b0);
                chk("por hold CSIO_B", bus.CSIO_B, 1'b1);
                chk("por hold CSUART_B", bus.CSUART_B, 1'b1);
            end else begin
                chk("por release RST_B", RST_B, 1'b1);
            end
        end

        for (int i = 0; i < 9; i++) begin
            bus.A = vecs[i].a; bus.ECLK = vecs[i].e; bus.BA = vecs[i].ba; bus.BS = vecs[i].bs;
            #1;
            chk($sformatf("vec%0d SYS_A8", i), bus.SYS_A8, vecs[i].a8);
            chk($sformatf("vec%0d CSIO_B", i), bus.CSIO_B, vecs[i].csio);
            chk($sformatf("vec%0d CSUART_B", i), bus.CSUART_B, vecs[i].csuart);
            chk($sformatf("vec%0d SYS_ECLK", i), bus.SYS_ECLK, vecs[i].e);
            tick();
        end

        // Bus-state latency.
        bus.BA = 1'b0; bus.BS = 1'b0; bus.ECLK = 1'b0;
        tick(); tick(); tick();
        bus.BS = 1'b1; bus.A = 16'hFFFE;
        #1;
        chk("iack SYS_A8", bus.SYS_A8, 1'b0);
        tick(); tick();
        chk("iack early IACK_B", IACK_B, 1'b1);
        tick();
        chk("iack IACK_B", IACK_B, 1'b0);
        chk("iack BUSACK_B", BUSACK_B, 1'b1);
        bus.BA = 1'b1;
        tick(); tick(); tick();
        chk("halt BUSACK_B", BUSACK_B, 1'b0);
        chk("halt IACK_B", IACK_B, 1'b1);

        // Random stream: strobes are the bus status seen 3 clocks earlier.
        for (int i = 0; i < 200; i++) begin
            logic [15:0] a;
            logic e, ba, bs, csio;
            a  = 16'($urandom);
            if ($urandom_range(1, 0) == 1) a[15:8] = 8'hFC;
            e  = 1'($urandom); ba = 1'($urandom); bs = 1'($urandom);
            bus.A = a; bus.ECLK = e; bus.BA = ba; bus.BS = bs;
            q.push_back('{iack: !(bs && !ba), busack: !(ba && bs)});
            #1;
            csio = !(a[15:8] == 8'hFC && e);
            chk("rnd SYS_A8", bus.SYS_A8, a[8] ^ (bs && !ba));
            chk("rnd CSIO_B", bus.CSIO_B, csio);
            chk("rnd CSUART_B", bus.CSUART_B, !(!csio && a[7:4] == 4'h0));
            tick();
            if (q.size() == 3) begin
                st_exp_t ex;
                ex = q.pop_front();
                chk("rnd IACK_B", IACK_B, ex.iack);
                chk("rnd BUSACK_B", BUSACK_B, ex.busack);
            end
        end

        bus.BA = 1'b0; bus.BS = 1'b0; bus.A = 16'h0000; bus.ECLK = 1'b0;

        // Bouncing switch never accepted.
        for (int i = 0; i < 60; i++) begin
            SW_RST_B = ((i / 5) % 2 == 1);
            tick();
            chk("bounce RST_B", RST_B, 1'b1);
        end
        SW_RST_B = 1'b1;
        repeat (5) tick();

        SW_RST_B = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            tick();
            chk($sformatf("press edge%0d RST_B", i), RST_B, (i < 19) ? 1'b1 : 1'b0);
        end
        SW_RST_B = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            tick();
            chk($sformatf("release edge%0d RST_B", i), RST_B, (i < 26) ? 1'b0 : 1'b1);
        end

        // Host bus reset, then a second 1-cycle pulse at hold count 5 restarts the hold.
        CPC_BUSRST_B = 1'b0;
        tick();
        CPC_BUSRST_B = 1'b1;
        chk("cpc edge1 RST_B", RST_B, 1'b1);
        tick();
        chk("cpc edge2 RST_B", RST_B, 1'b1);
        for (int i = 3; i <= 8; i++) begin
            tick();
            chk($sformatf("cpc edge%0d RST_B", i), RST_B, 1'b0);
        end
        CPC_BUSRST_B = 1'b0;
        tick();
        CPC_BUSRST_B = 1'b1;
        chk("cpc edge9 RST_B", RST_B, 1'b0);
        for (int i = 10; i <= 19; i++) begin
            tick();
            chk($sformatf("cpc edge%0d RST_B", i), RST_B, (i < 19) ? 1'b0 : 1'b1);
        end

        // RST together with a cause: hold count stays at 0 while the cause persists.
        RST = 1'b1; CPC_BUSRST_B = 1'b0;
        tick(); tick();
        RST = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rst+cause RST_B", RST_B, 1'b0);
        end
        CPC_BUSRST_B = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("rst+cause rel edge%0d RST_B", i), RST_B, (i < 10) ? 1'b0 : 1'b1);
        end

        // Divided clock: period 8, high 4.
        begin
            int highs, nrise, last_rise;
            highs = 0; nrise = 0; last_rise = -1;
            for (int i = 0; i < 32; i++) begin
                tick();
                samp[i] = SYS_Q_AUXCLK;
                if (samp[i]) highs++;
            end
            for (int i = 1; i < 32; i++) begin
                if (!samp[i-1] && samp[i]) begin
                    if (last_rise >= 0) chk("div period", 32'(i - last_rise), 32'd8);
                    last_rise = i;
                    nrise++;
                end
            end
            chk("div high count", 32'(highs), 32'd16);
            chk("div rise count ok", 32'(nrise >= 3), 32'd1);
        end

        DIP1 = 1'b1; bus.QCLK = 1'b0;
        tick();
        chk("qclk low", SYS_Q_AUXCLK, 1'b0);
        bus.QCLK = 1'b1; #1;
        chk("qclk high", SYS_Q_AUXCLK, 1'b1);
        tick(); tick(); tick(); tick();
        bus.QCLK = 1'b0; #1;
        chk("qclk low again", SYS_Q_AUXCLK, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/m6809_sys_glue.md
# m6809_sys_glue

Control logic for the 6809 CPU card's XC9572 CPLD, clocked from the auxiliary oscillator. It sits between the 6809 bus-status, clock and address pins and the 50-way system connector. It produces:
- the stretched, debounced system reset `RST_B`;
- bus-state strobes `IACK_B` and `BUSACK_B`;
- the vector-remap address bit `SYS_A8`;
- the E-qualified chip selects `CSIO_B` and `CSUART_B`;
- the system Q/aux clock `SYS_Q_AUXCLK`.

## Interface
Parameters:
- `RST_HOLD`, 1024: AUXCLK cycles that `RST_B` is held low after the last reset cause clears (≥2).
- `DEBOUNCE`, 16: consecutive stable synchronized samples needed to accept a `SW_RST_B` level change.
- `IO_PAGE`, 8'hFC: A15..A8 value of the I/O page.
- `UART_SLOT`, 4'h0: A7..A4 value of the UART within the I/O page.
- `AUX_DIV`, 8: divider for the aux clock output (even, ≥2).

Ports. One clock; reset is synchronous and active-high.
- `AUXCLK` in 1: the only clock.
- `RST` in 1: synchronous active-high reset (power-on).
- `SW_RST_B` in 1: reset pushbutton, raw and asynchronous.
- `CPC_BUSRST_B` in 1: host bus reset, asynchronous, active-low.
- `ECLK`, `QCLK` in 1: 6809 E and Q, asynchronous to AUXCLK.
- `BA`, `BS` in 1: 6809 bus status.
- `A` in 16: 6809 address.
- `DIP0`, `DIP1` in 1: configuration switches, 1 = open.
- `RST_B` out 1: system/CPU reset, active-low.
- `IACK_B` out 1: interrupt/reset vector fetch, active-low.
- `BUSACK_B` out 1: bus granted or CPU halted, active-low.
- `SYS_A8` out 1: remapped A8.
- `CSIO_B`, `CSUART_B` out 1: chip selects, active-low.
- `SYS_ECLK` out 1: buffered E.
- `SYS_Q_AUXCLK` out 1: Q or divided AUXCLK.

## Operation
- **Synchronizers.** `SW_RST_B`, `CPC_BUSRST_B`, `BA` and `BS` each pass through a 2-FF synchronizer. In `RST`, all synchronizer FFs load 1, except `BA`/`BS`, which load 0.
- **Debounce.**
  - Accepted switch level `sw_db` resets to 1.
  - A counter counts while the synchronized switch level differs from `sw_db` and clears to 0 when they match.
  - On reaching `DEBOUNCE-1`, `sw_db` takes the new level and the counter clears.
- **Reset FSM.**
  - States: HOLD and RUN. `RST` forces HOLD and loads the counter with 0.
  - Reset cause = `sw_db`==0 OR synchronized `CPC_BUSRST_B`==0.
  - HOLD: `RST_B`=0. While a cause is active, the counter is held at 0. Otherwise it increments; when it reaches `RST_HOLD-1`, go to RUN.
  - RUN: `RST_B`=1. Any cause returns the FSM to HOLD with the counter at 0.
  - `RST_B` is registered.
- **Bus state.** Decoded from the synchronized `BA`/`BS`:
  - `IACK_B` = !(¬BA ∧ BS), registered.
  - `BUSACK_B` = !(BA ∧ BS), registered.
  - Both reset to 1, and both are forced to 1 while the FSM is in HOLD.
- **Vector remap.** `SYS_A8` = `A[8]` XOR (`BS` ∧ ¬`BA`), using the raw pins, combinational. The 6809 drives the vector address during the vector-fetch cycle itself, so this path cannot be registered.
- **Chip selects.** Combinational, from raw pins:
  - `CSIO_B` = !(`A[15:8]`==`IO_PAGE` ∧ `ECLK` ∧ `RST_B`).
  - `CSUART_B` = !(`CSIO_B`==0 ∧ `A[7:4]`==`UART_SLOT`).
  - Both are forced to 1 in HOLD, so there are no strobes during reset.
- **Clocks.**
  - `SYS_ECLK` = `ECLK`, passed through.
  - `DIP1`=1: `SYS_Q_AUXCLK` = `QCLK`.
  - `DIP1`=0: `SYS_Q_AUXCLK` is a registered toggle every `AUX_DIV/2` AUXCLK cycles (AUXCLK/`AUX_DIV`, 50% duty). The divider resets to count 0 with the output at 0.
  - A `DIP1` change takes effect on the next AUXCLK edge.
- `DIP0` is reserved and ignored.

## Timing
- Reset values: `RST_B`=0, `IACK_B`=1, `BUSACK_B`=1, divided clock=0. `CSIO_B`/`CSUART_B`=1 because the FSM is in HOLD.
- A 1-cycle `RST` pulse followed by no cause: `RST_B` rises on the `RST_HOLD`-th edge after `RST` deasserts.
- `CPC_BUSRST_B` low → `RST_B` low after 3 edges (2 sync + 1 FSM).
- Switch press → `RST_B` low after 2 + `DEBOUNCE` + 1 edges. Bounces shorter than `DEBOUNCE` samples are ignored.
- `BA`/`BS` → `IACK_B`/`BUSACK_B`: 3 edges.
- A cause reasserting in HOLD restarts the full hold count.
- Simultaneous `RST` and cause: `RST` wins, and the counter stays held while the cause persists.
- Chip selects and `SYS_A8` have zero clock latency; their only delay is logic.

## Structure
- Shared package `m6809_glue_pkg`:
  - state enum {HOLD, RUN};
  - default constants for the I/O page, UART slot, hold length, debounce length and divider;
  - the bus-state encodings NORMAL=00, IACK=01, SYNC=10 and HALT=11, with bit order (BA,BS).
- One sub-module `sync2` (2-FF synchronizer, parameterized reset value), instantiated four times.
- Debounce, FSM, divider and decode stay in the top level.

## Test plan
- `RST` for 1 cycle with `RST_HOLD`=8 → `RST_B`=0 for exactly 8 edges, then 1. Chip selects stay 1 throughout, even with A=16'hFC00 and `ECLK`=1.
- `SW_RST_B` toggled every 5 cycles for 60 cycles (`DEBOUNCE`=16) → `RST_B` stays 1. A steady low press → `RST_B`=0 at edge 2+16+1, and it rises 8 edges after release is accepted.
- BA=0, BS=1, A=16'hFFFE → `SYS_A8`=0 immediately and `IACK_B`=0 after 3 edges. BA=BS=1 → `BUSACK_B`=0 and `IACK_B`=1.
- In RUN, A=16'hFC05, `ECLK`=1 → `CSIO_B`=0, `CSUART_B`=0. A=16'hFC15 → `CSUART_B`=1. `ECLK`=0 → both 1. A=16'hFB05 → both 1.
- `DIP1`=0, `AUX_DIV`=8 → `SYS_Q_AUXCLK` period 8 cycles, high 4. `DIP1`=1 → output follows `QCLK`.
- `CPC_BUSRST_B` pulsed low for 1 cycle mid-hold at count 5 → counter restarts and `RST_B` stays 0 for a full 8 edges after the pulse passes through the synchronizer.
